// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: pulses the PLL reset, qualifies lock, releases
// downstream domain resets in a staggered order and relocks after loss of lock.
module pll_lock_supervisor #(
  parameter int N_DOMAINS          = 3,
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 4,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic                 fail,
  output logic [CNT_W-1:0]     relock_count
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max_int(max_int(RST_PULSE_CYCLES, LOCK_TIMEOUT),
                                   max_int(LOCK_STABLE_CYCLES, STAGGER_CYCLES));
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam int RW = $clog2(MAX_RETRIES) + 1;
  localparam int IW = $clog2(N_DOMAINS) + 1;
  localparam logic [N_DOMAINS-1:0] DOM_ALL    = '1;
  localparam logic [N_DOMAINS-1:0] DOM_LSB    = N_DOMAINS'(1'b1);
  localparam logic [CNT_W-1:0]     RELOCK_MAX = '1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]        retries_q, retries_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pll_rst_q, pll_rst_d;
  logic [N_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;
  logic [CNT_W-1:0]     relock_q, relock_d;
  logic                 sync1_q, sync2_q;
  logic                 lock_s;

  assign lock_s = sync2_q;

  // Next-state and next-output computation for the supervisor FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retries_d    = retries_q;
    idx_d        = idx_q;
    pll_rst_d    = pll_rst_q;
    domain_rst_d = domain_rst_q;
    ready_d      = ready_q;
    fail_d       = fail_q;
    relock_d     = relock_q;

    case (state_q)
      S_RESET_PLL: begin
        pll_rst_d = 1'b1;
        if (cnt_q == CW'(RST_PULSE_CYCLES - 1)) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d     = '0;
          retries_d = retries_q + RW'(1);
          pll_rst_d = 1'b1;
          if (retries_q == RW'(MAX_RETRIES - 1)) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_RESET_PLL;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          cnt_d        = '0;
          retries_d    = '0;
          idx_d        = IW'(1);
          domain_rst_d = domain_rst_q & ~DOM_LSB;
          if (N_DOMAINS == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (!lock_s) begin
          state_d      = S_RESET_PLL;
          cnt_d        = '0;
          retries_d    = '0;
          idx_d        = '0;
          pll_rst_d    = 1'b1;
          domain_rst_d = DOM_ALL;
          ready_d      = 1'b0;
          relock_d     = (relock_q == RELOCK_MAX) ? relock_q : relock_q + CNT_W'(1);
        end else if (state_q == S_RUN) begin
          state_d = S_RUN;
        end else if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
          cnt_d        = '0;
          idx_d        = idx_q + IW'(1);
          domain_rst_d = domain_rst_q & ~(DOM_LSB << idx_q);
          if (idx_q == IW'(N_DOMAINS - 1)) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FAIL: begin
        pll_rst_d    = 1'b1;
        domain_rst_d = DOM_ALL;
        ready_d      = 1'b0;
        fail_d       = 1'b1;
      end
      default: begin
        state_d      = S_RESET_PLL;
        cnt_d        = '0;
        pll_rst_d    = 1'b1;
        domain_rst_d = DOM_ALL;
        ready_d      = 1'b0;
      end
    endcase
  end

  // State, output and lock-synchroniser registers with synchronous reset.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retries_q    <= '0;
      idx_q        <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= DOM_ALL;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      relock_q     <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      idx_q        <= idx_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
      relock_q     <= relock_d;
      sync1_q      <= pll_locked;
      sync2_q      <= sync1_q;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst   = domain_rst_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; edges are counted from the stimulus event
// and compared against hand-derived edge numbers.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic       fail;
  logic [1:0] relock_count;

  int checks = 0;
  int failures = 0;

  int ev_pll_fall, ev_pll_fall_last, ev_pll_rise, ev_pll_rise_last;
  int n_pll_fall, n_pll_rise;
  int ev_d[3];
  int ev_rdy, ev_all, ev_fail;

  pll_lock_supervisor #(
    .N_DOMAINS(3), .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT(16), .LOCK_STABLE_CYCLES(8),
    .STAGGER_CYCLES(2), .MAX_RETRIES(3), .CNT_W(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .domain_rst(domain_rst), .ready(ready), .fail(fail), .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    check({tag, ".pll_rst"}, int'(pll_rst), 1);
    check({tag, ".domain_rst"}, int'(domain_rst), 7);
    check({tag, ".ready"}, int'(ready), 0);
    check({tag, ".fail"}, int'(fail), 0);
    check({tag, ".relock"}, int'(relock_count), 0);
    rst = 1'b0;
  endtask

  // Runs n edges, toggling pll_locked after the given edge numbers (0 = unused).
  task automatic run_window(input int n, input int up_e, input int dn_e, input int up2_e);
    logic p_pll, p_rdy;
    logic [2:0] p_dom;
    p_pll = pll_rst; p_dom = domain_rst; p_rdy = ready;
    ev_pll_fall = -1; ev_pll_fall_last = -1; ev_pll_rise = -1; ev_pll_rise_last = -1;
    n_pll_fall = 0; n_pll_rise = 0;
    ev_d[0] = -1; ev_d[1] = -1; ev_d[2] = -1;
    ev_rdy = -1; ev_all = -1; ev_fail = -1;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (p_pll && !pll_rst) begin
        n_pll_fall++;
        if (ev_pll_fall < 0) ev_pll_fall = e;
        ev_pll_fall_last = e;
      end
      if (!p_pll && pll_rst) begin
        n_pll_rise++;
        if (ev_pll_rise < 0) ev_pll_rise = e;
        ev_pll_rise_last = e;
      end
      for (int i = 0; i < 3; i++)
        if (p_dom[i] && !domain_rst[i] && ev_d[i] < 0) ev_d[i] = e;
      if (!p_rdy && ready && ev_rdy < 0) ev_rdy = e;
      if (domain_rst == 3'b111 && !ready && ev_all < 0) ev_all = e;
      if (fail && ev_fail < 0) ev_fail = e;
      p_pll = pll_rst; p_dom = domain_rst; p_rdy = ready;
      if (e == up_e) pll_locked = 1'b1;
      if (e == dn_e) pll_locked = 1'b0;
      if (e == up2_e) pll_locked = 1'b1;
    end
  endtask

  // Locked rises after edge 6: release at 6+11, 6+13, 6+15.
  task automatic clean_bringup(input string tag);
    run_window(30, 6, 0, 0);
    check({tag, ".pll_rst_fall"}, ev_pll_fall, 4);
    check({tag, ".pll_rst_rises"}, n_pll_rise, 0);
    check({tag, ".d0_fall"}, ev_d[0], 17);
    check({tag, ".d1_fall"}, ev_d[1], 19);
    check({tag, ".d2_fall"}, ev_d[2], 21);
    check({tag, ".ready_rise"}, ev_rdy, 21);
    check({tag, ".dom_final"}, int'(domain_rst), 0);
    check({tag, ".fail"}, int'(fail), 0);
  endtask

  // Lock drops before edge 1, returns after edge 10; pulse 3..7, STABLE at 13.
  task automatic loss_in_run(input string tag, input int exp_relock);
    pll_locked = 1'b0;
    run_window(30, 10, 0, 0);
    check({tag, ".all_rst"}, ev_all, 3);
    check({tag, ".pll_rise"}, ev_pll_rise, 3);
    check({tag, ".pll_fall"}, ev_pll_fall, 7);
    check({tag, ".pll_pulses"}, n_pll_rise, 1);
    check({tag, ".d0_fall"}, ev_d[0], 21);
    check({tag, ".ready_rise"}, ev_rdy, 25);
    check({tag, ".relock"}, int'(relock_count), exp_relock);
  endtask

  initial begin
    tick();
    apply_reset("rst0");
    clean_bringup("clean");

    loss_in_run("loss1", 1);
    loss_in_run("sat2", 2);
    loss_in_run("sat3", 3);
    loss_in_run("sat4", 3);
    loss_in_run("sat5", 3);

    // Reset from RUN with relock_count saturated.
    apply_reset("rst_run");

    // Glitch: low after edge 14 (5 into STABLE), high after 15; STABLE re-entered at 18.
    run_window(35, 6, 14, 15);
    check("glitch.pll_fall", ev_pll_fall, 4);
    check("glitch.pll_pulses", n_pll_rise, 0);
    check("glitch.d0_fall", ev_d[0], 26);
    check("glitch.d1_fall", ev_d[1], 28);
    check("glitch.d2_fall", ev_d[2], 30);
    check("glitch.ready_rise", ev_rdy, 30);
    check("glitch.fail", int'(fail), 0);

    // Lose lock, relock, stop just after domain 0 releases, then reset.
    pll_locked = 1'b0;
    run_window(21, 10, 0, 0);
    check("midrel.d0_fall", ev_d[0], 21);
    check("midrel.dom", int'(domain_rst), 6);
    check("midrel.relock", int'(relock_count), 1);
    apply_reset("rst_rel");
    clean_bringup("clean2");

    // Never locks: pulses fall at 4/24/44, timeouts at 20/40/60.
    apply_reset("rst_nl");
    run_window(70, 0, 0, 0);
    check("nolock.falls", n_pll_fall, 3);
    check("nolock.rises", n_pll_rise, 3);
    check("nolock.first_fall", ev_pll_fall, 4);
    check("nolock.first_rise", ev_pll_rise, 20);
    check("nolock.last_fall", ev_pll_fall_last, 44);
    check("nolock.last_rise", ev_pll_rise_last, 60);
    check("nolock.fail_edge", ev_fail, 60);
    check("nolock.pll_rst", int'(pll_rst), 1);
    check("nolock.ready", int'(ready), 0);
    check("nolock.dom", int'(domain_rst), 7);
    pll_locked = 1'b1;
    run_window(20, 0, 0, 0);
    check("nolock.sticky_fail", int'(fail), 1);
    check("nolock.sticky_pll", int'(pll_rst), 1);
    check("nolock.sticky_falls", n_pll_fall, 0);
    apply_reset("rst_fail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
